// File: rtl/console_text_buffer.sv
// Character-cell frame store: terminal byte stream in, per-pixel codepoint/attribute out.
// Rows are kept in a circular buffer so a scroll only rewrites the row that becomes the bottom line.
module console_text_buffer #(
  parameter int unsigned COLUMNS           = 80,
  parameter int unsigned ROWS              = 30,
  parameter int unsigned CHAR_WIDTH        = 8,
  parameter int unsigned CHAR_HEIGHT       = 16,
  parameter logic [7:0]  DEFAULT_ATTRIBUTE = 8'h0F
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  output logic [7:0] codepoint,
  output logic [7:0] attribute,
  output logic [9:0] cx_out,
  output logic [9:0] cy_out,
  input  logic [7:0] char_in,
  input  logic [7:0] attribute_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [6:0] cursor_col,
  output logic [4:0] cursor_row
);

  localparam int unsigned CELLS = COLUMNS * ROWS;
  localparam int unsigned AW    = $clog2(CELLS);
  localparam int unsigned XW    = 10;
  localparam int unsigned CW    = 7;
  localparam int unsigned RW    = 5;
  localparam int unsigned PW    = RW + 1;
  localparam int unsigned CX_SH = $clog2(CHAR_WIDTH);
  localparam int unsigned CY_SH = $clog2(CHAR_HEIGHT);

  localparam logic [7:0]  SPACE = 8'h20;
  localparam logic [15:0] BLANK = {DEFAULT_ATTRIBUTE, SPACE};

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [15:0] mem [CELLS];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [RW-1:0] top_row_q, top_row_d;
  logic [RW-1:0] clr_row_q, clr_row_d;
  logic [CW-1:0] cursor_col_q, cursor_col_d;
  logic [RW-1:0] cursor_row_q, cursor_row_d;
  logic          char_ready_q, char_ready_d;
  logic [15:0]   rd_word_q, rd_word_d;
  logic [XW-1:0] cx_out_q, cy_out_q;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          accept;
  logic          advance;
  logic [PW-1:0] cur_phys;

  logic [XW-1:0] rd_col, rd_row, rd_phys;
  logic          rd_off;
  logic [AW-1:0] rd_addr;

  // Display read: cell lookup through the circular row base; never stalls.
  always_comb begin
    rd_col  = cx >> CX_SH;
    rd_row  = cy >> CY_SH;
    rd_off  = (rd_col >= XW'(COLUMNS)) || (rd_row >= XW'(ROWS));
    rd_phys = rd_row + XW'(top_row_q);
    if (rd_phys >= XW'(ROWS)) begin
      rd_phys = rd_phys - XW'(ROWS);
    end
    rd_addr = '0;
    if (!rd_off) begin
      rd_addr = AW'(rd_phys) * AW'(COLUMNS) + AW'(rd_col);
    end
    rd_word_d = rd_off ? BLANK : mem[rd_addr];
  end

  // Write-side control: init fill, byte decode, scroll and bottom-row clear.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    top_row_d    = top_row_q;
    clr_row_d    = clr_row_q;
    cursor_col_d = cursor_col_q;
    cursor_row_d = cursor_row_q;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = BLANK;
    advance      = 1'b0;
    accept       = char_valid && char_ready_q;

    cur_phys = {1'b0, cursor_row_q} + {1'b0, top_row_q};
    if (cur_phys >= PW'(ROWS)) begin
      cur_phys = cur_phys - PW'(ROWS);
    end

    case (state_q)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_addr = fill_q;
        if (fill_q == AW'(CELLS - 1)) begin
          fill_d       = '0;
          state_d      = ST_IDLE;
          top_row_d    = '0;
          cursor_col_d = '0;
          cursor_row_d = '0;
        end else begin
          fill_d = fill_q + AW'(1);
        end
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = AW'(clr_row_q) * AW'(COLUMNS) + fill_q;
        if (fill_q == AW'(COLUMNS - 1)) begin
          fill_d  = '0;
          state_d = ST_IDLE;
        end else begin
          fill_d = fill_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (accept) begin
          case (char_in)
            8'h0A: begin
              cursor_col_d = '0;
              advance      = 1'b1;
            end
            8'h0D: cursor_col_d = '0;
            8'h08: begin
              if (cursor_col_q != '0) begin
                cursor_col_d = cursor_col_q - CW'(1);
              end
            end
            8'h0C: begin
              state_d = ST_INIT;
              fill_d  = '0;
            end
            default: begin
              wr_en   = 1'b1;
              wr_addr = AW'(cur_phys) * AW'(COLUMNS) + AW'(cursor_col_q);
              wr_data = {attribute_in, char_in};
              if (cursor_col_q == CW'(COLUMNS - 1)) begin
                cursor_col_d = '0;
                advance      = 1'b1;
              end else begin
                cursor_col_d = cursor_col_q + CW'(1);
              end
            end
          endcase
        end
      end
      default: begin
        state_d = ST_INIT;
        fill_d  = '0;
      end
    endcase

    // At the bottom line the old top row becomes the new (blank) bottom row.
    if (advance) begin
      if (cursor_row_q < RW'(ROWS - 1)) begin
        cursor_row_d = cursor_row_q + RW'(1);
      end else begin
        clr_row_d = top_row_q;
        top_row_d = (top_row_q == RW'(ROWS - 1)) ? '0 : top_row_q + RW'(1);
        state_d   = ST_CLEAR;
        fill_d    = '0;
      end
    end

    char_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_pixel) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      fill_q       <= '0;
      top_row_q    <= '0;
      clr_row_q    <= '0;
      cursor_col_q <= '0;
      cursor_row_q <= '0;
      char_ready_q <= 1'b0;
      rd_word_q    <= BLANK;
      cx_out_q     <= '0;
      cy_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      top_row_q    <= top_row_d;
      clr_row_q    <= clr_row_d;
      cursor_col_q <= cursor_col_d;
      cursor_row_q <= cursor_row_d;
      char_ready_q <= char_ready_d;
      rd_word_q    <= rd_word_d;
      cx_out_q     <= cx;
      cy_out_q     <= cy;
    end
  end

  assign codepoint  = rd_word_q[7:0];
  assign attribute  = rd_word_q[15:8];
  assign cx_out     = cx_out_q;
  assign cy_out     = cy_out_q;
  assign char_ready = char_ready_q;
  assign cursor_col = cursor_col_q;
  assign cursor_row = cursor_row_q;

endmodule
